// File: rtl/fu_wb_arbiter_pkg.sv
// Shared types and defaults for the execute-stage writeback arbiter.
package fu_wb_arbiter_pkg;

  localparam int unsigned NrFuDefault        = 4;
  localparam int unsigned NrWbPortsDefault   = 2;
  localparam int unsigned FifoDepthDefault   = 2;
  localparam int unsigned XlenDefault        = 64;
  localparam int unsigned TransIdBitsDefault = 3;

  // One scoreboard write, at the default widths.
  typedef struct packed {
    logic [XlenDefault-1:0]        result;
    logic [TransIdBitsDefault-1:0] trans_id;
    logic                          ex_valid;
    logic [XlenDefault-1:0]        ex_cause;
  } wb_entry_t;

  // A single-entry FIFO still needs one pointer bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fu_wb_fifo.sv
// Per-unit result FIFO; the arbiter guarantees no push when full and no pop when empty.
module fu_wb_fifo
  import fu_wb_arbiter_pkg::*;
#(
  parameter  int unsigned FifoDepth = FifoDepthDefault,
  parameter  int unsigned DataWidth = 8,
  localparam int unsigned CntW      = $clog2(FifoDepth + 1),
  localparam int unsigned PtrW      = ptr_width(FifoDepth)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [DataWidth-1:0] data_i,
  output logic [DataWidth-1:0] data_o,
  output logic [CntW-1:0]      cnt_o,
  output logic                 full_o,
  output logic                 empty_o
);

  logic [DataWidth-1:0] mem_q [FifoDepth];
  logic [PtrW-1:0]      rd_q;
  logic [PtrW-1:0]      wr_q;
  logic [CntW-1:0]      cnt_q;

  function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(FifoDepth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wrap_inc(wr_q);
      if (pop_i)  rd_q <= wrap_inc(rd_q);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign cnt_o   = cnt_q;
  assign full_o  = (cnt_q == CntW'(FifoDepth));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/fu_wb_arbiter.sv
// Writeback arbiter: per-unit result FIFOs feeding NrWbPorts scoreboard write ports.
// Unit side: a result transfers when fu_valid_i & fu_ready_o; the scoreboard side always accepts.
module fu_wb_arbiter
  import fu_wb_arbiter_pkg::*;
#(
  parameter int unsigned NrFu        = NrFuDefault,
  parameter int unsigned NrWbPorts   = NrWbPortsDefault,
  parameter int unsigned FifoDepth   = FifoDepthDefault,
  parameter int unsigned XLEN        = XlenDefault,
  parameter int unsigned TransIdBits = TransIdBitsDefault,
  parameter bit          RoundRobin  = 1'b1
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    flush_i,
  input  logic [NrFu-1:0]                         fu_valid_i,
  output logic [NrFu-1:0]                         fu_ready_o,
  input  logic [NrFu-1:0][XLEN-1:0]               fu_result_i,
  input  logic [NrFu-1:0][TransIdBits-1:0]        fu_trans_id_i,
  input  logic [NrFu-1:0]                         fu_ex_valid_i,
  input  logic [NrFu-1:0][XLEN-1:0]               fu_ex_cause_i,
  output logic [NrWbPorts-1:0]                    wb_valid_o,
  output logic [NrWbPorts-1:0][XLEN-1:0]          wb_result_o,
  output logic [NrWbPorts-1:0][TransIdBits-1:0]   wb_trans_id_o,
  output logic [NrWbPorts-1:0]                    wb_ex_valid_o,
  output logic [NrWbPorts-1:0][XLEN-1:0]          wb_ex_cause_o,
  output logic [NrFu-1:0]                         fu_pending_o
);

  localparam int unsigned IdxW   = $clog2(NrFu);
  localparam int unsigned SumW   = IdxW + 1;
  localparam int unsigned NumW   = $clog2(NrFu + 1);
  localparam int unsigned CntW   = $clog2(FifoDepth + 1);

  typedef struct packed {
    logic [XLEN-1:0]        result;
    logic [TransIdBits-1:0] trans_id;
    logic                   ex_valid;
    logic [XLEN-1:0]        ex_cause;
  } entry_t;

  entry_t          in_entry   [NrFu];
  entry_t          head_entry [NrFu];
  entry_t          wb_entry   [NrWbPorts];
  logic [CntW-1:0] cnt        [NrFu];
  logic [IdxW-1:0] port_src   [NrWbPorts];

  logic [NrFu-1:0]      full, empty, cand, grant, accept, push, pop;
  logic [NrWbPorts-1:0] port_vld;
  logic [IdxW-1:0]      rr_q, scan_start, last_idx;
  logic                 live;

  assign live       = ~rst_i & ~flush_i;
  assign fu_ready_o = ~full & {NrFu{live}};
  assign accept     = fu_valid_i & fu_ready_o;
  // An empty FIFO offers its input directly (bypass); otherwise the head is offered.
  assign cand       = (~empty | fu_valid_i) & {NrFu{live}};
  assign push       = accept & ~(grant & empty);
  assign pop        = grant & ~empty;
  assign scan_start = RoundRobin ? rr_q : '0;

  for (genvar i = 0; i < NrFu; i++) begin : g_fu
    assign in_entry[i] = '{
      result:   fu_result_i[i],
      trans_id: fu_trans_id_i[i],
      ex_valid: fu_ex_valid_i[i],
      ex_cause: fu_ex_cause_i[i]
    };
    assign fu_pending_o[i] = (cnt[i] != '0) & ~rst_i;

    fu_wb_fifo #(
      .FifoDepth (FifoDepth),
      .DataWidth ($bits(entry_t))
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .push_i  (push[i]),
      .pop_i   (pop[i]),
      .data_i  (in_entry[i]),
      .data_o  (head_entry[i]),
      .cnt_o   (cnt[i]),
      .full_o  (full[i]),
      .empty_o (empty[i])
    );
  end

  // Walk units from scan_start; the k-th candidate found drives port k.
  always_comb begin : grant_scan
    logic [SumW-1:0] sum;
    logic [IdxW-1:0] idx;
    logic [NumW-1:0] n;
    grant    = '0;
    port_vld = '0;
    last_idx = '0;
    sum      = '0;
    idx      = '0;
    n        = '0;
    for (int p = 0; p < NrWbPorts; p++) port_src[p] = '0;
    for (int k = 0; k < NrFu; k++) begin
      sum = {1'b0, scan_start} + SumW'(k);
      if (sum >= SumW'(NrFu)) sum = sum - SumW'(NrFu);
      idx = sum[IdxW-1:0];
      if (cand[idx] && (n < NumW'(NrWbPorts))) begin
        grant[idx] = 1'b1;
        for (int p = 0; p < NrWbPorts; p++) begin
          if (n == NumW'(p)) begin
            port_vld[p] = 1'b1;
            port_src[p] = idx;
          end
        end
        last_idx = idx;
        n        = n + 1'b1;
      end
    end
  end

  always_comb begin : port_mux
    for (int p = 0; p < NrWbPorts; p++) begin
      wb_entry[p] = '0;
      if (port_vld[p]) begin
        wb_entry[p] = empty[port_src[p]] ? in_entry[port_src[p]] : head_entry[port_src[p]];
      end
    end
  end

  for (genvar p = 0; p < NrWbPorts; p++) begin : g_port
    assign wb_valid_o[p]    = port_vld[p];
    assign wb_result_o[p]   = wb_entry[p].result;
    assign wb_trans_id_o[p] = wb_entry[p].trans_id;
    assign wb_ex_valid_o[p] = wb_entry[p].ex_valid;
    assign wb_ex_cause_o[p] = wb_entry[p].ex_cause;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rr_q <= '0;
    end else if (|grant) begin
      rr_q <= (last_idx == IdxW'(NrFu - 1)) ? '0 : last_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Bench for fu_wb_arbiter: a fixed-priority and a round-robin instance share every input.
module tb_fu_wb_arbiter;

  localparam int NFU   = 4;
  localparam int NP    = 2;
  localparam int DEPTH = 2;
  localparam int XL    = 64;
  localparam int TID   = 3;
  localparam int EW    = 2 * XL + TID + 1;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst, flush;
  logic [NFU-1:0]           fu_valid;
  logic [NFU-1:0][XL-1:0]   fu_result;
  logic [NFU-1:0][TID-1:0]  fu_tid;
  logic [NFU-1:0]           fu_exv;
  logic [NFU-1:0][XL-1:0]   fu_cause;

  // index 0: fixed priority, index 1: round robin
  logic [NFU-1:0]          rdy  [2];
  logic [NFU-1:0]          pnd  [2];
  logic [NP-1:0]           wbv  [2];
  logic [NP-1:0][XL-1:0]   wbr  [2];
  logic [NP-1:0][TID-1:0]  wbt  [2];
  logic [NP-1:0]           wbx  [2];
  logic [NP-1:0][XL-1:0]   wbc  [2];

  fu_wb_arbiter #(.NrFu(NFU), .NrWbPorts(NP), .FifoDepth(DEPTH), .XLEN(XL),
                  .TransIdBits(TID), .RoundRobin(1'b0)) u_dut_fx (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .fu_valid_i(fu_valid), .fu_ready_o(rdy[0]), .fu_result_i(fu_result),
    .fu_trans_id_i(fu_tid), .fu_ex_valid_i(fu_exv), .fu_ex_cause_i(fu_cause),
    .wb_valid_o(wbv[0]), .wb_result_o(wbr[0]), .wb_trans_id_o(wbt[0]),
    .wb_ex_valid_o(wbx[0]), .wb_ex_cause_o(wbc[0]), .fu_pending_o(pnd[0])
  );

  fu_wb_arbiter #(.NrFu(NFU), .NrWbPorts(NP), .FifoDepth(DEPTH), .XLEN(XL),
                  .TransIdBits(TID), .RoundRobin(1'b1)) u_dut_rr (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .fu_valid_i(fu_valid), .fu_ready_o(rdy[1]), .fu_result_i(fu_result),
    .fu_trans_id_i(fu_tid), .fu_ex_valid_i(fu_exv), .fu_ex_cause_i(fu_cause),
    .wb_valid_o(wbv[1]), .wb_result_o(wbr[1]), .wb_trans_id_o(wbt[1]),
    .wb_ex_valid_o(wbx[1]), .wb_ex_cause_o(wbc[1]), .fu_pending_o(pnd[1])
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // reference model: one queue per unit per instance, plus a scan pointer
  logic [EW-1:0] mq [2][NFU][$];
  int            rr_m [2];

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] in_ent(input int u);
    return {fu_result[u], fu_tid[u], fu_exv[u], fu_cause[u]};
  endfunction

  // Expected outputs for this cycle from the queues, then commit the edge.
  task automatic model_step(input int m);
    logic [EW-1:0]  exp_q [$];
    bit             g  [NFU];
    int             sz [NFU];
    logic [NFU-1:0] er, ep;
    int             start, last, u;
    er = '0; ep = '0; last = -1;
    for (int i = 0; i < NFU; i++) begin
      g[i]  = 1'b0;
      sz[i] = mq[m][i].size();
    end
    if (rst) begin
      for (int i = 0; i < NFU; i++) mq[m][i].delete();
      rr_m[m] = 0;
    end else begin
      for (int i = 0; i < NFU; i++) begin
        er[i] = !flush && (sz[i] < DEPTH);
        ep[i] = sz[i] > 0;
      end
      if (flush) begin
        for (int i = 0; i < NFU; i++) mq[m][i].delete();
        rr_m[m] = 0;
      end else begin
        start = (m == 1) ? rr_m[m] : 0;
        for (int k = 0; k < NFU; k++) begin
          u = (start + k) % NFU;
          if ((sz[u] > 0 || fu_valid[u]) && exp_q.size() < NP) begin
            exp_q.push_back(sz[u] > 0 ? mq[m][u][0] : in_ent(u));
            g[u] = 1'b1;
            last = u;
          end
        end
        for (int i = 0; i < NFU; i++) begin
          if (g[i] && sz[i] > 0) void'(mq[m][i].pop_front());
          if (fu_valid[i] && sz[i] < DEPTH && !(g[i] && sz[i] == 0))
            mq[m][i].push_back(in_ent(i));
        end
        if (last >= 0) rr_m[m] = (last + 1) % NFU;
      end
    end
    for (int p = 0; p < NP; p++) begin
      check($sformatf("model m%0d wb_valid[%0d]", m, p), wbv[m][p], p < exp_q.size());
      check($sformatf("model m%0d wb_entry[%0d]", m, p),
            {wbr[m][p], wbt[m][p], wbx[m][p], wbc[m][p]},
            (p < exp_q.size()) ? exp_q[p] : '0);
    end
    check($sformatf("model m%0d ready", m), rdy[m], er);
    check($sformatf("model m%0d pending", m), pnd[m], ep);
  endtask

  // driver tasks
  task automatic settle();
    @(negedge clk);
  endtask

  task automatic advance();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    fu_valid = '0; fu_result = '0; fu_tid = '0; fu_exv = '0; fu_cause = '0;
  endtask

  task automatic drive_unit(input int u, input bit v, input logic [TID-1:0] id);
    fu_valid[u]  = v;
    fu_tid[u]    = id;
    fu_result[u] = {32'(u), 29'd0, id};
    fu_exv[u]    = 1'b0;
    fu_cause[u]  = '0;
  endtask

  task automatic reset_cycle();
    rst = 1'b1; flush = 1'b0; set_idle();
    settle();
    advance();
    rst = 1'b0;
  endtask

  typedef struct {
    bit          rst;
    bit          flush;
    logic [3:0]  valid;
    logic [11:0] ids;     // {unit3, unit2, unit1, unit0}
    logic [1:0]  e_wbv;
    logic [2:0]  e_id0;
    logic [2:0]  e_id1;
    logic [3:0]  e_rdy;
    logic [3:0]  e_pnd;
  } vec_t;

  function automatic vec_t mkv(input bit r, input bit f, input logic [3:0] v, input logic [11:0] ids,
                               input logic [1:0] wv, input logic [2:0] i0, input logic [2:0] i1,
                               input logic [3:0] rd, input logic [3:0] pd);
    vec_t x;
    x.rst = r; x.flush = f; x.valid = v; x.ids = ids;
    x.e_wbv = wv; x.e_id0 = i0; x.e_id1 = i1; x.e_rdy = rd; x.e_pnd = pd;
    return x;
  endfunction

  initial begin
    vec_t          tbl [14];
    logic [11:0]   i0123, i4567;
    logic [5:0]    bp_rdy;
    logic [TID-1:0] wq [$];
    int            sent, got;

    i0123 = {3'd3, 3'd2, 3'd1, 3'd0};
    i4567 = {3'd7, 3'd6, 3'd5, 3'd4};
    // Round-robin instance, starting empty with the scan pointer at 3.
    tbl[0]  = mkv(0, 1, 4'b0000, i0123, 2'b00, 0, 0, 4'b0000, 4'b0000);
    tbl[1]  = mkv(0, 0, 4'b1111, i0123, 2'b11, 0, 1, 4'b1111, 4'b0000);
    tbl[2]  = mkv(0, 0, 4'b0000, i0123, 2'b11, 2, 3, 4'b1111, 4'b1100);
    tbl[3]  = mkv(0, 0, 4'b0000, i0123, 2'b00, 0, 0, 4'b1111, 4'b0000);
    tbl[4]  = mkv(0, 0, 4'b1111, i4567, 2'b11, 4, 5, 4'b1111, 4'b0000);
    tbl[5]  = mkv(0, 0, 4'b1111, i0123, 2'b11, 6, 7, 4'b1111, 4'b1100);
    tbl[6]  = mkv(0, 1, 4'b1111, i0123, 2'b00, 0, 0, 4'b0000, 4'b1111);
    tbl[7]  = mkv(0, 0, 4'b0000, i0123, 2'b00, 0, 0, 4'b1111, 4'b0000);
    tbl[8]  = mkv(0, 0, 4'b0010, i0123, 2'b01, 1, 0, 4'b1111, 4'b0000);
    tbl[9]  = mkv(0, 0, 4'b1111, i0123, 2'b11, 2, 3, 4'b1111, 4'b0000);
    tbl[10] = mkv(0, 0, 4'b1111, i4567, 2'b11, 0, 1, 4'b1111, 4'b0011);
    tbl[11] = mkv(0, 0, 4'b1111, i0123, 2'b11, 6, 7, 4'b1111, 4'b1111);
    tbl[12] = mkv(1, 0, 4'b1111, i0123, 2'b00, 0, 0, 4'b0000, 4'b0000);
    tbl[13] = mkv(0, 0, 4'b1000, {3'd4, 9'd0}, 2'b01, 4, 0, 4'b1111, 4'b0000);

    for (int i = 0; i < 2; i++) rr_m[i] = 0;

    // reset state
    rst = 1'b1; flush = 1'b0; set_idle();
    settle();
    check("reset wb_valid", wbv[1], 0);
    check("reset ready", rdy[1], 0);
    check("reset pending", pnd[1], 0);
    advance();
    rst = 1'b0;

    // single bypass
    drive_unit(2, 1'b1, 3'd5);
    fu_result[2] = 64'hABCD;
    settle();
    check("bypass wb_valid", wbv[1], 2'b01);
    check("bypass result", wbr[1][0], 64'hABCD);
    check("bypass trans_id", wbt[1][0], 3'd5);
    check("bypass pending", pnd[1], 0);
    check("bypass ready", rdy[1], 4'b1111);
    advance();
    set_idle();
    settle();
    check("bypass pending after", pnd[1], 0);
    advance();

    // table: oversubscription, flush, reset mid-operation
    for (int t = 0; t < 14; t++) begin
      rst = tbl[t].rst; flush = tbl[t].flush;
      for (int u = 0; u < NFU; u++) drive_unit(u, tbl[t].valid[u], tbl[t].ids[3*u +: 3]);
      settle();
      check($sformatf("vec%0d wb_valid", t), wbv[1], tbl[t].e_wbv);
      if (tbl[t].e_wbv[0]) check($sformatf("vec%0d id0", t), wbt[1][0], tbl[t].e_id0);
      if (tbl[t].e_wbv[1]) check($sformatf("vec%0d id1", t), wbt[1][1], tbl[t].e_id1);
      check($sformatf("vec%0d ready", t), rdy[1], tbl[t].e_rdy);
      check($sformatf("vec%0d pending", t), pnd[1], tbl[t].e_pnd);
      advance();
    end
    rst = 1'b0; flush = 1'b0;

    // backpressure on the fixed-priority instance: units 0 and 1 hold both ports
    reset_cycle();
    bp_rdy = 6'b100011;
    for (int c = 0; c < 6; c++) begin
      drive_unit(0, 1'b1, 3'd0);
      drive_unit(1, c < 4, 3'd0);
      drive_unit(2, 1'b0, 3'd0);
      drive_unit(3, 1'b1, 3'(c));
      settle();
      check($sformatf("backpressure ready3 c%0d", c), rdy[0][3], bp_rdy[c]);
      if (c == 4) begin
        check("backpressure first pop valid", wbv[0], 2'b11);
        check("backpressure first pop unit", wbr[0][1][63:32], 32'd3);
        check("backpressure first pop id", wbt[0][1], 3'd0);
      end
      advance();
    end
    set_idle();
    for (int c = 0; c < 3; c++) begin settle(); advance(); end

    // wrap-around: eight ordered IDs through unit 3 with intermittent grants
    reset_cycle();
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 300 && got < 8; cyc++) begin
      drive_unit(0, 1'($urandom_range(0, 1)), 3'd0);
      drive_unit(1, 1'($urandom_range(0, 1)), 3'd0);
      drive_unit(2, 1'b0, 3'd0);
      drive_unit(3, sent < 8, 3'(sent));
      settle();
      if (fu_valid[3] && rdy[0][3]) begin
        wq.push_back(3'(sent));
        sent++;
      end
      for (int p = 0; p < NP; p++) begin
        if (wbv[0][p] && wbr[0][p][63:32] == 32'd3) begin
          if (wq.size() == 0) begin
            tests_run++; tests_failed++;
            $display("FAIL wrap duplicate: got id %0d expected none", wbt[0][p]);
          end else begin
            check("wrap id order", wbt[0][p], wq.pop_front());
          end
          got++;
        end
      end
      advance();
    end
    check("wrap count", got, 8);
    set_idle();

    // randomized traffic against the model on both instances
    reset_cycle();
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 59) == 0);
      flush = ($urandom_range(0, 24) == 0);
      for (int u = 0; u < NFU; u++) begin
        fu_valid[u]  = ($urandom_range(0, 99) < 60);
        fu_result[u] = {$urandom, $urandom};
        fu_tid[u]    = 3'($urandom);
        fu_exv[u]    = 1'($urandom_range(0, 1));
        fu_cause[u]  = {$urandom, $urandom};
      end
      settle();
      advance();
    end
    rst = 1'b0; flush = 1'b0; set_idle();
    for (int c = 0; c < 4; c++) begin settle(); advance(); end

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
